// File: rtl/fe_mux_pkg.sv
// rtl/fe_mux_pkg.sv - shared types and lane framing constants for the front-end mux link
package fe_mux_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ALIGNED = 2'd1,
        ST_DATA    = 2'd2
    } fe_state_e;

    // Shared with the transmitter so both ends agree on idle and start markers.
    localparam logic [3:0] TRAIN_NIBBLE_DEF = 4'hA;
    localparam logic [3:0] START_NIBBLE_DEF = 4'h5;

endpackage

// File: rtl/fe_sync_fifo.sv
// rtl/fe_sync_fifo.sv - first-word fall-through synchronous FIFO with drop-on-full reporting
module fe_sync_fifo #(
    parameter int W          = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         drop,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_pop   = pop & ~empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
    assign do_push  = push & (~full | do_pop);
    assign drop     = push & full & ~do_pop;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fe_ddr_deser.sv
// rtl/fe_ddr_deser.sv - DDR lane deserializer: nibble framing, training lock, word assembly
module fe_ddr_deser
    import fe_mux_pkg::*;
#(
    parameter int         NIBBLES_PER_WORD = 4,
    parameter logic [3:0] TRAIN_NIBBLE     = TRAIN_NIBBLE_DEF,
    parameter logic [3:0] START_NIBBLE     = START_NIBBLE_DEF,
    parameter int         LOCK_COUNT       = 8,
    parameter int         FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_diff_0,
    input  logic                          in_diff_180,
    input  logic                          frame_sync,
    output logic [4*NIBBLES_PER_WORD-1:0] m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          locked,
    output logic                          overflow,
    output logic [7:0]                    err_cnt
);
    localparam int W     = 4 * NIBBLES_PER_WORD;
    localparam int IDX_W = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;
    localparam int TC_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NIBBLES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [TC_W-1:0]  LOCK_LAST = TC_W'(LOCK_COUNT - 1);
    localparam logic [TC_W-1:0]  TC_ONE    = TC_W'(1);

    logic             phase_q;
    logic [1:0]       nib_lo;
    logic [3:0]       nib_q;
    logic             nib_valid;
    fe_state_e        state;
    logic [TC_W-1:0]  train_cnt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     word_q;
    logic [W-1:0]     push_word;
    logic             slip;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;

    // frame_sync landing on the first half of a nibble means the framing has slipped.
    assign slip    = frame_sync & ~phase_q;
    assign push    = nib_valid & ~slip & (state == ST_DATA) & (idx == LAST_IDX);
    assign pop     = m_valid & m_ready;
    assign m_valid = ~fifo_empty;

    always_comb begin
        push_word          = word_q;
        push_word[W-4 +: 4] = nib_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            nib_lo    <= 2'b00;
            nib_q     <= 4'h0;
            nib_valid <= 1'b0;
        end else begin
            phase_q   <= frame_sync ? 1'b0 : ~phase_q;
            nib_valid <= phase_q;
            if (!phase_q) nib_lo <= {in_diff_180, in_diff_0};
            else          nib_q  <= {in_diff_180, in_diff_0, nib_lo};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            locked    <= 1'b0;
            train_cnt <= '0;
            idx       <= '0;
            word_q    <= '0;
            err_cnt   <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            if (fifo_drop) overflow <= 1'b1;
            if (slip) begin
                state     <= ST_HUNT;
                locked    <= 1'b0;
                train_cnt <= '0;
                idx       <= '0;
                if (locked && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (nib_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (nib_q != TRAIN_NIBBLE) begin
                            train_cnt <= '0;
                        end else if (train_cnt == LOCK_LAST) begin
                            state     <= ST_ALIGNED;
                            locked    <= 1'b1;
                            train_cnt <= '0;
                        end else begin
                            train_cnt <= train_cnt + TC_ONE;
                        end
                    end
                    ST_ALIGNED: begin
                        if (nib_q == START_NIBBLE) begin
                            state <= ST_DATA;
                            idx   <= '0;
                        end else if (nib_q != TRAIN_NIBBLE) begin
                            state  <= ST_HUNT;
                            locked <= 1'b0;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                    end
                    ST_DATA: begin
                        word_q[{idx, 2'b00} +: 4] <= nib_q;
                        if (idx == LAST_IDX) begin
                            state <= ST_ALIGNED;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                    default: begin
                        state  <= ST_HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    fe_sync_fifo #(
        .W          (W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .full      (fifo_full),
        .drop      (fifo_drop),
        .pop       (pop),
        .pop_data  (m_data),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fe_ddr_deser.sv
// tb/tb_fe_ddr_deser.sv - scoreboard bench for fe_ddr_deser with a nibble-level reference model
module tb_fe_ddr_deser;

    localparam int DEPTH = 4;
    localparam logic [3:0] TRN = 4'hA;
    localparam logic [3:0] STR = 4'h5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_diff_0 = 1'b0;
    logic        in_diff_180 = 1'b0;
    logic        frame_sync = 1'b0;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        locked;
    logic        overflow;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    fe_ddr_deser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_diff_0   (in_diff_0),
        .in_diff_180 (in_diff_180),
        .frame_sync  (frame_sync),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .locked      (locked),
        .overflow    (overflow),
        .err_cnt     (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = hunting, 1 = aligned idle, 2 = collecting a word.
    int          md_state;
    int          m_train;
    int          m_err;
    bit          m_ovf;
    logic [3:0]  m_dq[$];
    logic [15:0] exp_q[$];
    bit          pend_v;
    logic [3:0]  pend;
    bit          fs_t;
    bit          rnd_rdy = 1'b0;
    logic        mid_valid;
    logic        prv_v = 1'b0;
    logic        prv_r = 1'b0;
    logic [15:0] prv_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        md_state = 0;
        m_train  = 0;
        m_err    = 0;
        m_ovf    = 1'b0;
        pend_v   = 1'b0;
        fs_t     = 1'b0;
        m_dq.delete();
        exp_q.delete();
    endfunction

    function automatic void model_apply(input logic [3:0] n);
        logic [15:0] w;
        case (md_state)
            0: begin
                if (n == TRN) begin
                    m_train++;
                    if (m_train == 8) begin
                        md_state = 1;
                        m_train  = 0;
                    end
                end else begin
                    m_train = 0;
                end
            end
            1: begin
                if (n == STR) begin
                    md_state = 2;
                    m_dq.delete();
                end else if (n != TRN) begin
                    md_state = 0;
                    if (m_err < 255) m_err++;
                end
            end
            default: begin
                m_dq.push_back(n);
                if (m_dq.size() == 4) begin
                    w = {m_dq[3], m_dq[2], m_dq[1], m_dq[0]};
                    m_dq.delete();
                    md_state = 1;
                    if (exp_q.size() < DEPTH) exp_q.push_back(w);
                    else m_ovf = 1'b1;
                end
            end
        endcase
    endfunction

    // Called at the falling edge that opens a nibble; returns at the falling edge opening the next one.
    task automatic send_nibble(input logic [3:0] n);
        if (pend_v) model_apply(pend);
        pend   = n;
        pend_v = 1'b1;
        if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
        in_diff_0   = n[0];
        in_diff_180 = n[1];
        frame_sync  = 1'b0;
        @(negedge clk);
        mid_valid   = m_valid;
        in_diff_0   = n[2];
        in_diff_180 = n[3];
        fs_t        = ~fs_t;
        frame_sync  = fs_t;
        @(negedge clk);
        frame_sync  = 1'b0;
        check("locked", {31'd0, locked}, {31'd0, md_state != 0});
        check("err_cnt", {24'd0, err_cnt}, m_err);
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic send_word(input logic [15:0] w);
        send_nibble(STR);
        for (int i = 0; i < 4; i++) send_nibble(w[4*i +: 4]);
    endtask

    task automatic slip();
        pend_v = 1'b0;
        if (md_state != 0 && m_err < 255) m_err++;
        md_state = 0;
        m_train  = 0;
        m_dq.delete();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        check("slip_locked", {31'd0, locked}, 32'd0);
        check("slip_err", {24'd0, err_cnt}, m_err);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prv_v = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (prv_v && !prv_r) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {16'd0, m_data}, {16'd0, prv_d});
            end
            if (rst_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none at %0t", m_data, $time);
                end else begin
                    check("m_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                end
            end
            prv_v = m_valid & rst_n;
            prv_r = m_ready;
            prv_d = m_data;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] w;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        release_reset();

        // Seven training nibbles then a foreign one must not lock.
        repeat (7) send_nibble(TRN);
        send_nibble(4'h3);
        send_nibble(TRN);
        check("no_lock_7", {31'd0, locked}, 32'd0);
        repeat (8) send_nibble(TRN);
        check("lock_after_8", {31'd0, locked}, 32'd1);

        // Single word with latency probe.
        m_ready = 1'b1;
        w = 16'h4321;
        send_word(w);
        check("lat_before", {31'd0, m_valid}, 32'd0);
        send_nibble(TRN);
        check("lat_2cyc", {31'd0, mid_valid}, 32'd1);
        repeat (2) send_nibble(TRN);

        // Backpressure: five words into a four-entry FIFO.
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_word(16'($urandom));
            send_nibble(TRN);
        end
        check("bp_overflow", {31'd0, overflow}, 32'd1);
        check("bp_queued", exp_q.size(), 32'd4);
        m_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) send_nibble(TRN);
        send_nibble(TRN);
        check("bp_drained", {31'd0, m_valid}, 32'd0);

        // Slip two nibbles into a word.
        send_nibble(STR);
        send_nibble(4'h7);
        send_nibble(4'h8);
        slip();
        check("slip_err_one", {24'd0, err_cnt}, 32'd1);
        repeat (9) send_nibble(TRN);
        check("relock", {31'd0, locked}, 32'd1);

        // Bad idle nibbles drive err_cnt to saturation.
        for (int k = 0; k < 300; k++) begin
            send_nibble(4'hF);
            repeat (9) send_nibble(TRN);
        end
        check("err_sat", {24'd0, err_cnt}, 32'hFF);

        // Randomized traffic with random consumer stalls.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (md_state == 0) repeat (9) send_nibble(TRN);
            repeat ($urandom_range(0, 3)) send_nibble(TRN);
            if ($urandom_range(0, 7) == 0) send_nibble(($urandom_range(0, 1) != 0) ? 4'hF : 4'h3);
            if ($urandom_range(0, 9) == 0) begin
                send_nibble(STR);
                send_nibble(4'($urandom));
                slip();
            end else begin
                send_word(16'($urandom));
            end
        end
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        repeat (2) send_nibble(TRN);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) send_nibble(TRN);
        check("rnd_drained", exp_q.size(), 32'd0);

        // Asynchronous reset with two words held in the FIFO.
        m_ready = 1'b0;
        if (md_state == 0) repeat (9) send_nibble(TRN);
        send_word(16'hBEEF);
        send_word(16'h1234);
        send_nibble(TRN);
        send_nibble(TRN);
        check("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        release_reset();
        m_ready = 1'b1;
        repeat (9) send_nibble(TRN);
        send_word(16'hC0DE);
        repeat (3) send_nibble(TRN);
        check("final_queue", exp_q.size(), 32'd0);
        check("final_valid", {31'd0, m_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
